// File: rtl/key_word_rot_sched_if.sv
// key_word_rot_sched_if
// ---------------------
// Bundles the control pulse, input handshake, output handshake and result
// fields of key_word_rot_sched.
//
// Handshake semantics (both directions):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   The producer keeps valid and data stable until the transfer happens.
//   ready may depend combinationally on the consumer's state, but never on
//   the producer's valid in the same cycle.
//
// Signals:
//   start       : one-cycle pulse that begins a new key schedule
//   inValid     : inWord holds w[i-1]
//   inReady     : block accepts inWord this cycle
//   inWord      : previous key word w[i-1]
//   outValid    : output registers hold a result
//   outReady    : downstream accepts the result
//   outWord     : rotated or passed-through word
//   outNeedsSub : downstream must apply SubWord to outWord
//   rconWord    : {rc, zeros} when Rcon applies, else 0
//   wordIndex   : index i of the word on the output
//   done        : last word of the schedule has been accepted
// Modports:
//   master : the side that drives words in and takes results out
//   slave  : the scheduler block
interface key_word_rot_sched_if #(
  parameter int WORD = 32
);
  logic            start;
  logic            inValid;
  logic            inReady;
  logic [WORD-1:0] inWord;
  logic            outValid;
  logic            outReady;
  logic [WORD-1:0] outWord;
  logic            outNeedsSub;
  logic [WORD-1:0] rconWord;
  logic [5:0]      wordIndex;
  logic            done;

  modport master (
    output start, inValid, inWord, outReady,
    input  inReady, outValid, outWord, outNeedsSub, rconWord, wordIndex, done
  );

  modport slave (
    input  start, inValid, inWord, outReady,
    output inReady, outValid, outWord, outNeedsSub, rconWord, wordIndex, done
  );
endinterface

// File: rtl/key_word_rot_sched.sv
// key_word_rot_sched
// ------------------
// Sequential AES key-expansion word scheduler. Takes the stream of previous
// words w[i-1] for i = NK .. 4*(NK+7)-1, tracks i internally, and per word
// decides whether to rotate it, which Rcon word goes with it and whether the
// downstream S-box stage must apply SubWord. One register stage, one word
// per clock when the output is drained every cycle.
//
// Ports:
//   clk       : system clock, all state on the rising edge
//   rst       : synchronous active-high reset
//   bus       : key_word_rot_sched_if.slave (start, in/out handshakes, results)
//   state_dbg : current FSM state (0 IDLE, 1 RUN, 2 FINISH)
module key_word_rot_sched #(
  parameter int BYTE       = 8,
  parameter int WORD_BYTES = 4,
  parameter int NK         = 4,
  parameter int ROT_BYTES  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  key_word_rot_sched_if.slave        bus,
  output logic [1:0]                 state_dbg
);
  localparam int WORD = BYTE * WORD_BYTES;
  localparam int LAST = 4 * (NK + 7) - 1;

  localparam logic [5:0] LAST_IDX = 6'(LAST);
  localparam logic [5:0] NK_IDX   = 6'(NK);
  localparam logic [3:0] NK_M1    = 4'(NK - 1);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("key_word_rot_sched: NK must be 4, 6 or 8");
  end
  if (ROT_BYTES < 0 || ROT_BYTES >= WORD_BYTES) begin : g_bad_rot
    $error("key_word_rot_sched: ROT_BYTES must be in 0..WORD_BYTES-1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  // phase = (NK - i mod NK) mod NK: zero exactly when i is a multiple of NK,
  // so the rotate decision needs no divider.
  logic [3:0]      phase_q, phase_d;
  logic [7:0]      rc_q, rc_d;
  logic            out_valid_q, out_valid_d;
  logic [WORD-1:0] out_word_q, out_word_d;
  logic            out_sub_q, out_sub_d;
  logic [WORD-1:0] rcon_q, rcon_d;
  logic [5:0]      out_idx_q, out_idx_d;

  logic            in_ready;
  logic            done;
  logic            accept;
  logic            is_rot;
  logic            is_sub_only;
  logic [2*WORD-1:0] dbl;
  logic [WORD-1:0] rotated;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FINISH: if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (bus.start)                            state_d = S_RUN;
        else if (accept && (idx_q == LAST_IDX))   state_d = S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. start blocks acceptance in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_RUN:    in_ready = !bus.start && (!out_valid_q || bus.outReady);
      S_FINISH: done     = 1'b1;
      default:  ;
    endcase
  end

  assign accept    = in_ready && bus.inValid;
  assign state_dbg = state_q;

  // Rotate left by ROT_BYTES: the window of a doubled word picks the
  // wrapped bytes without a zero-width slice when ROT_BYTES is 0.
  assign dbl         = {bus.inWord, bus.inWord};
  assign rotated     = dbl[2*WORD-1-ROT_BYTES*BYTE -: WORD];
  assign is_rot      = (phase_q == 4'd0);
  assign is_sub_only = (NK == 8) && (phase_q == 4'd4);

  // Datapath next state
  always_comb begin
    idx_d       = idx_q;
    phase_d     = phase_q;
    rc_d        = rc_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_sub_d   = out_sub_q;
    rcon_d      = rcon_q;
    out_idx_d   = out_idx_q;
    if (bus.start) begin
      // Restart drops any pending result; data registers keep their
      // contents but are hidden behind outValid=0.
      idx_d       = NK_IDX;
      phase_d     = 4'd0;
      rc_d        = 8'h01;
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_idx_d   = idx_q;
      idx_d       = idx_q + 6'd1;
      phase_d     = is_rot ? NK_M1 : (phase_q - 4'd1);
      if (is_rot) begin
        out_word_d = rotated;
        out_sub_d  = 1'b1;
        rcon_d     = {rc_q, {(WORD-8){1'b0}}};
        rc_d       = xtime(rc_q);
      end else if (is_sub_only) begin
        out_word_d = bus.inWord;
        out_sub_d  = 1'b1;
        rcon_d     = '0;
      end else begin
        out_word_d = bus.inWord;
        out_sub_d  = 1'b0;
        rcon_d     = '0;
      end
    end else if (out_valid_q && bus.outReady) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      phase_q     <= '0;
      rc_q        <= 8'h01;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_sub_q   <= 1'b0;
      rcon_q      <= '0;
      out_idx_q   <= '0;
    end else begin
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      rc_q        <= rc_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_sub_q   <= out_sub_d;
      rcon_q      <= rcon_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign bus.inReady     = in_ready;
  assign bus.done        = done;
  assign bus.outValid    = out_valid_q;
  assign bus.outWord     = out_word_q;
  assign bus.outNeedsSub = out_sub_q;
  assign bus.rconWord    = rcon_q;
  assign bus.wordIndex   = out_idx_q;
endmodule

// File: doc/key_word_rot_sched.md
Name: key_word_rot_sched

Overview:
- Sequential, parametrised successor of the single-word byte rotator used in AES key expansion.
- Accepts the stream of previous-words w[i-1] for i = NK .. 4*(NK+7)-1 over a valid/ready handshake and tracks the word index i internally.
- Per word, decides whether to rotate, produces the matching Rcon word, and flags whether downstream SubWord must be applied.
- Supports AES-128/192/256 via NK and sits between the round-key register file and the S-box/XOR stage.

Parameters:
- BYTE, 8, bits per byte.
- WORD_BYTES, 4, bytes per word; WORD = BYTE*WORD_BYTES.
- NK, 4, key length in words; legal values 4, 6, 8 (elaboration error otherwise).
- ROT_BYTES, 1, left-rotation amount in bytes; legal range 0..WORD_BYTES-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse: begin a new schedule, i=NK, rc=8'h01.
- inValid  input  1  inWord is valid.
- inReady  output  1  block can accept inWord this cycle.
- inWord  input  WORD  w[i-1].
- outValid  output  1  output registers hold a result.
- outReady  input  1  downstream accepts the result.
- outWord  output  WORD  processed word (rotated or passed through).
- outNeedsSub  output  1  downstream must apply SubWord to outWord.
- rconWord  output  WORD  {rc, zeros} when Rcon applies, else 0.
- wordIndex  output  6  index i of the word currently on the output.
- done  output  1  last word (i = 4*(NK+7)-1) has been accepted; held until start or rst.

Behaviour:
- Reset state: inReady=0, outValid=0, outWord=0, outNeedsSub=0, rconWord=0, wordIndex=0, done=0, internal i=0, rc=8'h01, state IDLE.
- States:
  - IDLE: inReady=0. start -> RUN, i=NK, rc=8'h01, done=0.
  - RUN: accepts words. Acceptance of the word with i = LAST moves to FINISH.
  - FINISH: inReady=0, done=1. start -> RUN and reinitialises as in IDLE.
- Acceptance: inValid && inReady. In RUN, inReady = !outValid || outReady, so the output stage is a single register stage with throughput 1 word/clk.
- Latency: exactly 1 cycle from acceptance to outValid=1.
- Per accepted word, results are registered with wordIndex=i:
  - i mod NK == 0: outWord = inWord rotated left by ROT_BYTES bytes (MSB bytes wrap to LSB; for ROT_BYTES=1, {a0,a1,a2,a3} -> {a1,a2,a3,a0}). outNeedsSub=1, rconWord={rc, (WORD-BYTE) zeros}. After use, rc <= xtime(rc) = {rc[6:0],0} ^ (rc[7] ? 8'h1B : 8'h00).
  - NK==8 and i mod 8 == 4: outWord = inWord unrotated, outNeedsSub=1, rconWord=0, rc unchanged.
  - Otherwise: outWord = inWord, outNeedsSub=0, rconWord=0.
- After each acceptance, i <= i+1. LAST = 43 for NK=4, 51 for NK=6, 59 for NK=8.
- Output hold: while outValid && !outReady, all output registers hold stable and inReady=0.
- Output drain: outValid clears on outReady when no new word is accepted in the same cycle. Results of the final word drain normally while in FINISH.
- Simultaneous events:
  - start with inValid in the same cycle: start wins; the input is not accepted and inReady=0 in that cycle.
  - start in RUN: restarts the schedule and clears outValid, discarding the pending result.
- rst at any time returns every register to its reset value in the next cycle; no partial result is emitted.
- Computing i mod NK uses a per-NK down-counter (no divider). Counter widths are sized for i <= 59.

Test Plan:
- NK=4, start, inWord=32'h09cf4f3c at i=4 -> one cycle later outWord=32'hcf4f3c09, outNeedsSub=1, rconWord=32'h01000000, wordIndex=4.
- NK=4, 40 words streamed with outReady=1 -> Rcon at i=4,8,..,40 equals 01,02,04,08,10,20,40,80,1B,36; all other words pass through with outNeedsSub=0. done=1 after i=43 is accepted; inReady=0 afterwards.
- NK=8 -> i=8: rotated, rc=01. i=12: outWord==inWord, outNeedsSub=1, rconWord=0. i=16: rc=02. done after i=59.
- NK=6, outReady held low 3 cycles with inValid=1 -> inReady=0, outputs stable for 3 cycles, no word lost or duplicated; index sequence stays contiguous.
- start asserted together with inValid mid-RUN at i=20 -> input not accepted, outValid=0 next cycle, next accepted word has wordIndex=NK and rconWord=32'h01000000.
- rst asserted mid-stream at i=17 -> next cycle all outputs at reset values; inReady=0 until start.
